// File: rtl/vend_sequencer.sv
// vend_sequencer: three-product vending controller with coin credit and change return.
// Define REFUND_TIMEOUT_EN to refund credit after TIMEOUT_CYCLES idle cycles in SELECTED.
`timescale 1ns/1ps
module vend_sequencer #(
   parameter int PRICE1         = 2,
   parameter int PRICE2         = 3,
   parameter int PRICE3         = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] btn_req,
   input  logic       coin_valid,
   input  logic [2:0] coin_value,
   output logic       coin_reject,
   output logic [2:0] product_sel,
   output logic       dispense_req,
   input  logic       dispense_done,
   output logic       change_valid,
   output logic [2:0] change_coin,
   input  logic       change_ready,
   output logic [4:0] credit,
   output logic       delivered
);

   typedef enum logic [2:0] {
      IDLE,
      SELECTED,
      DISPENSE,
      CHANGE,
      DONE
   } state_t;

   state_t     state;
   logic       refund;

   logic       coin_open;
   logic       coin_legal;
   logic       coin_ok;
   logic       btn_any;
   logic       timeout_fire;
   logic [4:0] coin_sum;
   logic [2:0] btn_pick;
   logic [4:0] price;
   logic [4:0] remain_sale;
   logic [4:0] remain_chg;

   function automatic logic [2:0] pick_coin(input logic [4:0] amt);
      if (amt >= 5'd5)
         return 3'd5;
      else if (amt >= 5'd2)
         return 3'd2;
      else
         return 3'd1;
   endfunction

   assign btn_any    = |btn_req;
   assign coin_open  = (state == IDLE) || (state == SELECTED);
   assign coin_sum   = credit + {2'b00, coin_value};
   assign coin_legal = (coin_value == 3'd1) || (coin_value == 3'd2) ||
                       (coin_value == 3'd5);
   assign coin_ok    = coin_valid && coin_open && coin_legal &&
                       (coin_sum <= 5'd15);

   // lowest index wins when several buttons arrive together
   always_comb begin
      btn_pick = 3'b000;
      if (btn_req[0])
         btn_pick = 3'b001;
      else if (btn_req[1])
         btn_pick = 3'b010;
      else if (btn_req[2])
         btn_pick = 3'b100;
   end

   always_comb begin
      price = 5'd0;
      unique case (1'b1)
         product_sel[0]: price = 5'(PRICE1);
         product_sel[1]: price = 5'(PRICE2);
         product_sel[2]: price = 5'(PRICE3);
         default:        price = 5'd0;
      endcase
   end

   assign remain_sale = credit - price;
   assign remain_chg  = credit - {2'b00, change_coin};

`ifdef REFUND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer;
   logic          timer_hit;

   assign timer_hit    = (timer == TW'(TIMEOUT_CYCLES - 1));
   assign timeout_fire = timer_hit && !coin_ok && !btn_any;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timer <= '0;
      else if (state != SELECTED || coin_ok || btn_any)
         timer <= '0;
      else if (!timer_hit)
         timer <= timer + 1'b1;
   end
`else
   assign timeout_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         credit       <= 5'd0;
         product_sel  <= 3'b000;
         dispense_req <= 1'b0;
         change_valid <= 1'b0;
         change_coin  <= 3'd0;
         coin_reject  <= 1'b0;
         delivered    <= 1'b0;
         refund       <= 1'b0;
      end else begin
         coin_reject <= coin_valid && !coin_ok;
         delivered   <= 1'b0;
         if (coin_ok)
            credit <= coin_sum;
         unique case (state)
            IDLE: begin
               if (btn_any) begin
                  product_sel <= btn_pick;
                  state       <= SELECTED;
               end
            end
            SELECTED: begin
               if (btn_any) begin
                  product_sel <= btn_pick;
               end else if (credit >= price) begin
                  state        <= DISPENSE;
                  dispense_req <= 1'b1;
               end else if (timeout_fire) begin
                  if (credit == 5'd0) begin
                     state       <= IDLE;
                     product_sel <= 3'b000;
                  end else begin
                     state        <= CHANGE;
                     refund       <= 1'b1;
                     change_valid <= 1'b1;
                     change_coin  <= pick_coin(credit);
                  end
               end
            end
            DISPENSE: begin
               if (dispense_done) begin
                  dispense_req <= 1'b0;
                  credit       <= remain_sale;
                  if (remain_sale != 5'd0) begin
                     state        <= CHANGE;
                     change_valid <= 1'b1;
                     change_coin  <= pick_coin(remain_sale);
                  end else begin
                     state     <= DONE;
                     delivered <= 1'b1;
                  end
               end
            end
            CHANGE: begin
               // coin only moves on a completed handshake
               if (change_ready) begin
                  credit <= remain_chg;
                  if (remain_chg == 5'd0) begin
                     state        <= DONE;
                     change_valid <= 1'b0;
                     change_coin  <= 3'd0;
                     delivered    <= !refund;
                  end else begin
                     change_coin <= pick_coin(remain_chg);
                  end
               end
            end
            DONE: begin
               state       <= IDLE;
               product_sel <= 3'b000;
               refund      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed vector table plus hand sequences for reset and timeout.
`timescale 1ns/1ps
module tb_vend_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] btn_req;
   logic       coin_valid;
   logic [2:0] coin_value;
   logic       coin_reject;
   logic [2:0] product_sel;
   logic       dispense_req;
   logic       dispense_done;
   logic       change_valid;
   logic [2:0] change_coin;
   logic       change_ready;
   logic [4:0] credit;
   logic       delivered;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] btn;
      logic       cv;
      logic [2:0] cval;
      logic       done;
      logic       rdy;
      logic [14:0] exp;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   vend_sequencer #(
      .PRICE1(2),
      .PRICE2(3),
      .PRICE3(4),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_req(btn_req),
      .coin_valid(coin_valid),
      .coin_value(coin_value),
      .coin_reject(coin_reject),
      .product_sel(product_sel),
      .dispense_req(dispense_req),
      .dispense_done(dispense_done),
      .change_valid(change_valid),
      .change_coin(change_coin),
      .change_ready(change_ready),
      .credit(credit),
      .delivered(delivered)
   );

   function automatic logic [14:0] ex(
      input logic       rej,
      input logic [2:0] sel,
      input logic       dreq,
      input logic       chv,
      input logic [2:0] cc,
      input logic [4:0] cr,
      input logic       del
   );
      return {rej, sel, dreq, chv, cc, cr, del};
   endfunction

   task automatic add(
      input logic [2:0] b, input logic v, input logic [2:0] val,
      input logic d, input logic r, input logic [14:0] e
   );
      vec_t t;
      t.btn = b; t.cv = v; t.cval = val; t.done = d; t.rdy = r; t.exp = e;
      vq.push_back(t);
   endtask

   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] act;
      act = {coin_reject, product_sel, dispense_req, change_valid,
             change_coin, credit, delivered};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got rej=%0b sel=%b dreq=%0b cv=%0b cc=%0d cr=%0d del=%0b, want rej=%0b sel=%b dreq=%0b cv=%0b cc=%0d cr=%0d del=%0b",
                  name, act[14], act[13:11], act[10], act[9], act[8:6], act[5:1], act[0],
                  exp[14], exp[13:11], exp[10], exp[9], exp[8:6], exp[5:1], exp[0]);
      end
   endtask

   task automatic step(
      input logic [2:0] b, input logic v, input logic [2:0] val,
      input logic d, input logic r
   );
      @(negedge clk);
      btn_req = b; coin_valid = v; coin_value = val;
      dispense_done = d; change_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      btn_req = 3'b000; coin_valid = 1'b0; coin_value = 3'd0;
      dispense_done = 1'b0; change_ready = 1'b0;

      //   btn     cv val  dn rdy     rej sel    dreq cv cc  cr  del
      // single exact-price sale, product 1
      add(3'b001, 0, 0, 0, 0, ex(0, 3'b001, 0, 0, 0, 0, 0));
      add(3'b000, 1, 2, 0, 0, ex(0, 3'b001, 0, 0, 0, 2, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b001, 1, 0, 0, 2, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b001, 1, 0, 0, 2, 0));
      add(3'b000, 0, 0, 1, 0, ex(0, 3'b001, 0, 0, 0, 0, 1));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b000, 0, 0, 0, 0, 0));
      // overpay with 5, change 2 then 1
      add(3'b001, 0, 0, 0, 0, ex(0, 3'b001, 0, 0, 0, 0, 0));
      add(3'b000, 1, 5, 0, 0, ex(0, 3'b001, 0, 0, 0, 5, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b001, 1, 0, 0, 5, 0));
      add(3'b000, 0, 0, 1, 1, ex(0, 3'b001, 0, 1, 2, 3, 0));
      add(3'b000, 0, 0, 0, 1, ex(0, 3'b001, 0, 1, 1, 1, 0));
      add(3'b000, 0, 0, 0, 1, ex(0, 3'b001, 0, 0, 0, 0, 1));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b000, 0, 0, 0, 0, 0));
      // credit ceiling and illegal coins
      add(3'b000, 1, 5, 0, 0, ex(0, 3'b000, 0, 0, 0, 5, 0));
      add(3'b000, 1, 5, 0, 0, ex(0, 3'b000, 0, 0, 0, 10, 0));
      add(3'b000, 1, 5, 0, 0, ex(0, 3'b000, 0, 0, 0, 15, 0));
      add(3'b000, 1, 2, 0, 0, ex(1, 3'b000, 0, 0, 0, 15, 0));
      add(3'b000, 1, 3, 0, 0, ex(1, 3'b000, 0, 0, 0, 15, 0));
      add(3'b000, 1, 1, 0, 0, ex(1, 3'b000, 0, 0, 0, 15, 0));
      // spend 15 on product 3, change stalls, coin in CHANGE refused
      add(3'b100, 0, 0, 0, 0, ex(0, 3'b100, 0, 0, 0, 15, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b100, 1, 0, 0, 15, 0));
      add(3'b000, 0, 0, 1, 0, ex(0, 3'b100, 0, 1, 5, 11, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b100, 0, 1, 5, 11, 0));
      add(3'b000, 1, 1, 0, 0, ex(1, 3'b100, 0, 1, 5, 11, 0));
      add(3'b000, 0, 0, 0, 1, ex(0, 3'b100, 0, 1, 5, 6, 0));
      add(3'b000, 0, 0, 0, 1, ex(0, 3'b100, 0, 1, 1, 1, 0));
      add(3'b000, 0, 0, 0, 1, ex(0, 3'b100, 0, 0, 0, 0, 1));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b000, 0, 0, 0, 0, 0));
      // multi-bit button, lowest wins
      add(3'b110, 0, 0, 0, 0, ex(0, 3'b010, 0, 0, 0, 0, 0));
      add(3'b000, 1, 2, 0, 0, ex(0, 3'b010, 0, 0, 0, 2, 0));
      add(3'b000, 1, 1, 0, 0, ex(0, 3'b010, 0, 0, 0, 3, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b010, 1, 0, 0, 3, 0));
      add(3'b000, 0, 0, 1, 0, ex(0, 3'b010, 0, 0, 0, 0, 1));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b000, 0, 0, 0, 0, 0));
      // reselect with coin in the same cycle
      add(3'b001, 0, 0, 0, 0, ex(0, 3'b001, 0, 0, 0, 0, 0));
      add(3'b100, 1, 2, 0, 0, ex(0, 3'b100, 0, 0, 0, 2, 0));
      add(3'b000, 1, 2, 0, 0, ex(0, 3'b100, 0, 0, 0, 4, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b100, 1, 0, 0, 4, 0));
      add(3'b000, 0, 0, 1, 0, ex(0, 3'b100, 0, 0, 0, 0, 1));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b000, 0, 0, 0, 0, 0));
      // credit kept from IDLE, coin refused during DISPENSE
      add(3'b000, 1, 1, 0, 0, ex(0, 3'b000, 0, 0, 0, 1, 0));
      add(3'b001, 0, 0, 0, 0, ex(0, 3'b001, 0, 0, 0, 1, 0));
      add(3'b000, 1, 1, 0, 0, ex(0, 3'b001, 0, 0, 0, 2, 0));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b001, 1, 0, 0, 2, 0));
      add(3'b000, 1, 2, 0, 0, ex(1, 3'b001, 1, 0, 0, 2, 0));
      add(3'b000, 0, 0, 1, 0, ex(0, 3'b001, 0, 0, 0, 0, 1));
      add(3'b000, 0, 0, 0, 0, ex(0, 3'b000, 0, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", ex(0, 3'b000, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         btn_req       = vq[i].btn;
         coin_valid    = vq[i].cv;
         coin_value    = vq[i].cval;
         dispense_done = vq[i].done;
         change_ready  = vq[i].rdy;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vq[i].exp);
      end

      // asynchronous reset while dispensing
      step(3'b001, 0, 0, 0, 0);
      step(3'b000, 1, 2, 0, 0);
      step(3'b000, 0, 0, 0, 0);
      check("pre_reset_disp", ex(0, 3'b001, 1, 0, 0, 2, 0));
      #2 reset = 1'b1;
      #1 check("async_reset_disp", ex(0, 3'b000, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      step(3'b000, 0, 0, 0, 0);
      check("idle_after_reset", ex(0, 3'b000, 0, 0, 0, 0, 0));
      step(3'b010, 0, 0, 0, 0);
      check("select_after_reset", ex(0, 3'b010, 0, 0, 0, 0, 0));

      // asynchronous reset while returning change
      step(3'b000, 1, 5, 0, 0);
      step(3'b000, 0, 0, 0, 0);
      step(3'b000, 0, 0, 1, 0);
      check("pre_reset_chg", ex(0, 3'b010, 0, 1, 2, 2, 0));
      #2 reset = 1'b1;
      #1 check("async_reset_chg", ex(0, 3'b000, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      step(3'b000, 0, 0, 0, 0);
      check("idle_after_reset2", ex(0, 3'b000, 0, 0, 0, 0, 0));

      // waiting in SELECTED with insufficient credit
      step(3'b100, 0, 0, 0, 0);
      step(3'b000, 1, 2, 0, 0);
      check("wait_start", ex(0, 3'b100, 0, 0, 0, 2, 0));
`ifdef REFUND_TIMEOUT_EN
      repeat (19) step(3'b000, 0, 0, 0, 0);
      check("timeout_pre", ex(0, 3'b100, 0, 0, 0, 2, 0));
      step(3'b000, 0, 0, 0, 0);
      check("timeout_refund", ex(0, 3'b100, 0, 1, 2, 2, 0));
      step(3'b000, 0, 0, 0, 1);
      check("refund_done", ex(0, 3'b100, 0, 0, 0, 0, 0));
      step(3'b000, 0, 0, 0, 0);
      check("refund_idle", ex(0, 3'b000, 0, 0, 0, 0, 0));
      step(3'b001, 0, 0, 0, 0);
      repeat (19) step(3'b000, 0, 0, 0, 0);
      check("zero_timeout_pre", ex(0, 3'b001, 0, 0, 0, 0, 0));
      step(3'b000, 0, 0, 0, 0);
      check("zero_timeout_idle", ex(0, 3'b000, 0, 0, 0, 0, 0));
`else
      repeat (30) step(3'b000, 0, 0, 0, 0);
      check("no_timeout", ex(0, 3'b100, 0, 0, 0, 2, 0));
      step(3'b000, 1, 2, 0, 0);
      step(3'b000, 0, 0, 0, 0);
      check("late_dispense", ex(0, 3'b100, 1, 0, 0, 4, 0));
      step(3'b000, 0, 0, 1, 0);
      check("late_delivered", ex(0, 3'b100, 0, 0, 0, 0, 1));
      step(3'b000, 0, 0, 0, 0);
      check("late_idle", ex(0, 3'b000, 0, 0, 0, 0, 0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
